fetch_sequencer: RTL

- Fetch-stage controller that feeds PipelineIF.
- Generates the fetch PC and drives a request/grant/response handshake to instruction memory.
- Buffers returned instructions in order, tagged with their PC, and presents them downstream under valid/ready.
- Handles branch/mispredict redirects: flushes the buffer and discards stale in-flight responses.

---
 rtl/fetch_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: issues credit-limited instruction fetches, buffers in-order
// responses tagged with their PC, and discards stale responses after a redirect.
module fetch_sequencer #(
  parameter int                  ADDR_LEN  = 32,
  parameter int                  INSN_LEN  = 32,
  parameter logic [ADDR_LEN-1:0] RESET_PC  = '0,
  parameter int                  BUF_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  output logic                imem_req_o,
  output logic [ADDR_LEN-1:0] imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [INSN_LEN-1:0] imem_rdata_i,
  input  logic                redirect_i,
  input  logic [ADDR_LEN-1:0] redirect_pc_i,
  output logic                if_valid_o,
  input  logic                if_ready_i,
  output logic [ADDR_LEN-1:0] if_pc_o,
  output logic [INSN_LEN-1:0] if_inst_o
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0]         DEPTH_CNT  = BUF_DEPTH[CW:0];
  localparam logic [ADDR_LEN-1:0] ALIGN_MASK = {{(ADDR_LEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]       outstanding_q, outstanding_d;
  logic [CW-1:0]       occupancy_q, occupancy_d;
  logic [PW-1:0]       pcq_wr_q, pcq_rd_q, buf_wr_q, buf_rd_q;
  logic [ADDR_LEN-1:0] hold_pc_q;
  logic [INSN_LEN-1:0] hold_inst_q;

  logic [ADDR_LEN-1:0] pcq_mem  [BUF_DEPTH];
  logic [ADDR_LEN-1:0] buf_pc   [BUF_DEPTH];
  logic [INSN_LEN-1:0] buf_inst [BUF_DEPTH];

  logic        buf_empty, grant, accept_rsp, rsp_dec, pop;
  logic [CW:0] credit_used;

  // In-flight fetches plus buffered entries share one credit pool, so the buffer never overflows.
  assign buf_empty   = (occupancy_q == '0);
  assign credit_used = {1'b0, outstanding_q} + {1'b0, occupancy_q};
  assign imem_req_o  = (state_q == RUN) && !redirect_i && (credit_used < DEPTH_CNT);
  assign imem_addr_o = fetch_pc_q;
  assign grant       = imem_req_o && imem_gnt_i;
  assign accept_rsp  = imem_rvalid_i && (state_q == RUN) && !redirect_i;
  assign rsp_dec     = imem_rvalid_i && (outstanding_q != '0);

  assign if_valid_o = !buf_empty && !redirect_i;
  assign pop        = if_valid_o && if_ready_i;
  assign if_pc_o    = buf_empty ? hold_pc_q   : buf_pc[buf_rd_q];
  assign if_inst_o  = buf_empty ? hold_inst_q : buf_inst[buf_rd_q];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(rsp_dec);
    occupancy_d   = redirect_i ? '0 : occupancy_q + CW'(accept_rsp) - CW'(pop);

    if (grant) fetch_pc_d = fetch_pc_q + ADDR_LEN'(4);
    if (redirect_i) fetch_pc_d = redirect_pc_i & ALIGN_MASK;

    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redirect_i) state_d = (outstanding_d != '0) ? DRAIN : RUN;
      DRAIN:   state_d = (outstanding_d != '0) ? DRAIN : RUN;
      default: state_d = BOOT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      occupancy_q   <= '0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
      buf_wr_q      <= '0;
      buf_rd_q      <= '0;
      hold_pc_q     <= '0;
      hold_inst_q   <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      occupancy_q   <= occupancy_d;
      if (redirect_i) begin
        pcq_rd_q <= pcq_wr_q;
        buf_rd_q <= buf_wr_q;
      end else begin
        if (grant) pcq_wr_q <= pcq_wr_q + PW'(1);
        if (accept_rsp) begin
          pcq_rd_q <= pcq_rd_q + PW'(1);
          buf_wr_q <= buf_wr_q + PW'(1);
        end
        if (pop) buf_rd_q <= buf_rd_q + PW'(1);
      end
      // Track the presented head so the outputs hold steady once the buffer empties.
      if (!buf_empty) begin
        hold_pc_q   <= buf_pc[buf_rd_q];
        hold_inst_q <= buf_inst[buf_rd_q];
      end
    end
  end

  // NOTE: storage arrays are not reset; pointers and occupancy alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (grant) pcq_mem[pcq_wr_q] <= fetch_pc_q;
    if (accept_rsp) begin
      buf_pc[buf_wr_q]   <= pcq_mem[pcq_rd_q];
      buf_inst[buf_wr_q] <= imem_rdata_i;
    end
  end

endmodule
